// File: rtl/sha256_core.sv
// Single-block SHA-256 compression engine: one pre-padded 512-bit block in,
// 256-bit digest out 65 cycles later, always starting from the standard IV.
package sha256_pkg;
  localparam int BLOCK_SIZE = 256;
endpackage

module sha256_core
  import sha256_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [2*BLOCK_SIZE-1:0] msg_i,
  output logic [BLOCK_SIZE-1:0]   md_o,
  output logic                    valid_o
);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bigSigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bigSigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] smallSigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] smallSigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t      r_state;
  state_t      w_next;
  logic [6:0]  r_round;
  logic [31:0] r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
  logic [31:0] r_w [16];
  logic        w_load;
  logic        w_step;
  logic        w_finish;
  logic [31:0] w_t1;
  logic [31:0] w_t2;
  logic [31:0] w_wNext;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // r_round reaching 64 marks the extra edge that folds the working set into the IV.
  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_step   = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          w_load = 1'b1;
          w_next = S_ROUND;
        end
      end
      S_ROUND: begin
        if (r_round[6]) begin
          w_finish = 1'b1;
          w_next   = S_DONE;
        end else begin
          w_step = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // r_w[0] is always W_t; w_wNext is W_(t+16), entering at the top of the window.
  assign w_t1    = r_h + bigSigma1(r_e) + ((r_e & r_f) ^ (~r_e & r_g)) + K[r_round[5:0]] + r_w[0];
  assign w_t2    = bigSigma0(r_a) + ((r_a & r_b) ^ (r_a & r_c) ^ (r_b & r_c));
  assign w_wNext = smallSigma1(r_w[14]) + r_w[9] + smallSigma0(r_w[1]) + r_w[0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_round <= '0;
      r_a <= '0; r_b <= '0; r_c <= '0; r_d <= '0;
      r_e <= '0; r_f <= '0; r_g <= '0; r_h <= '0;
      for (int i = 0; i < 16; i++) r_w[i] <= '0;
      md_o    <= '0;
      valid_o <= 1'b0;
    end else if (w_load) begin
      for (int i = 0; i < 16; i++) r_w[i] <= msg_i[2*BLOCK_SIZE-1-32*i -: 32];
      r_a <= IV[255:224]; r_b <= IV[223:192]; r_c <= IV[191:160]; r_d <= IV[159:128];
      r_e <= IV[127:96];  r_f <= IV[95:64];   r_g <= IV[63:32];   r_h <= IV[31:0];
      r_round <= '0;
      valid_o <= 1'b0;
    end else if (w_step) begin
      r_h <= r_g;
      r_g <= r_f;
      r_f <= r_e;
      r_e <= r_d + w_t1;
      r_d <= r_c;
      r_c <= r_b;
      r_b <= r_a;
      r_a <= w_t1 + w_t2;
      for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
      r_w[15] <= w_wNext;
      r_round <= r_round + 7'd1;
    end else if (w_finish) begin
      md_o <= {IV[255:224] + r_a, IV[223:192] + r_b, IV[191:160] + r_c, IV[159:128] + r_d,
               IV[127:96]  + r_e, IV[95:64]   + r_f, IV[63:32]   + r_g, IV[31:0]    + r_h};
      valid_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sha256_core.sv
// Self-checking bench for sha256_core: random and known blocks are scored against
// a loop-based SHA-256 model through an expected-digest queue.
module tb_sha256_core;
  import sha256_pkg::*;

  logic                    clk;
  logic                    rst;
  logic                    start;
  logic [2*BLOCK_SIZE-1:0] msg;
  logic [BLOCK_SIZE-1:0]   md;
  logic                    valid;

  int checks = 0;
  int errors = 0;
  int cycleCnt = 0;

  typedef struct {
    logic [255:0] digest;
    int           acceptCycle;
  } exp_t;
  exp_t expQ[$];

  localparam logic [255:0] EMPTY_MD = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] ABC_MD   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};

  localparam logic [31:0] KTAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] HINIT [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  sha256_core dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .msg_i   (msg),
    .md_o    (md),
    .valid_o (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycleCnt++;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Straight FIPS 180-4: full 64-word schedule, then 64 rounds, then add the IV.
  function automatic logic [255:0] refHash(input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] s0, s1, t1, t2;
    logic [255:0] res;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int i = 0; i < 8; i++) v[i] = HINIT[i];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
           + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KTAB[t] + w[t];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255-32*i -: 32] = HINIT[i] + v[i];
    return res;
  endfunction

  function automatic logic [511:0] randBlock();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drives one start pulse; a start the DUT should ignore pushes no expectation.
  task automatic applyStimulus(input logic [511:0] blk, input bit expectAccept);
    exp_t e;
    @(negedge clk);
    msg   = blk;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (expectAccept) begin
      e.digest      = refHash(blk);
      e.acceptCycle = cycleCnt;
      expQ.push_back(e);
    end
    checkOutput("valid_low_after_start", {255'h0, valid}, 256'h0);
    start = 1'b0;
    msg   = randBlock();
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_timeout: %0d digests still pending after %0d cycles", expQ.size(), budget);
      expQ.delete();
    end
  endtask

  // Monitor: every rising edge of valid must match the oldest expected digest and latency.
  initial begin
    logic prevValid;
    exp_t e;
    prevValid = 1'b0;
    forever begin
      @(negedge clk);
      if (valid && !prevValid) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_digest: got %h expected none", md);
        end else begin
          e = expQ.pop_front();
          checkOutput("digest", md, e.digest);
          checkOutput("latency", 256'(cycleCnt - e.acceptCycle), 256'd65);
        end
      end
      prevValid = valid;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got cycle %0d expected < 200000", cycleCnt);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [511:0] blk;
    rst   = 1'b1;
    start = 1'b0;
    msg   = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_md", md, 256'h0);
    checkOutput("reset_valid", {255'h0, valid}, 256'h0);
    rst = 1'b0;

    $display("[TB] empty block");
    applyStimulus(EMPTY_BLK, 1'b1);
    waitDone(80);
    checkOutput("empty_known", md, EMPTY_MD);

    $display("[TB] back-to-back restart with abc");
    applyStimulus(ABC_BLK, 1'b1);
    repeat (30) @(negedge clk);
    checkOutput("md_held_while_busy", md, EMPTY_MD);
    checkOutput("valid_low_while_busy", {255'h0, valid}, 256'h0);
    waitDone(80);
    checkOutput("abc_known", md, ABC_MD);

    $display("[TB] start ignored while busy");
    applyStimulus(ABC_BLK, 1'b1);
    repeat (18) @(negedge clk);
    applyStimulus(EMPTY_BLK, 1'b0);
    waitDone(80);
    checkOutput("abc_after_ignored", md, ABC_MD);

    $display("[TB] hold for 100 cycles");
    for (int i = 0; i < 10; i++) begin
      repeat (10) @(negedge clk);
      checkOutput("hold_md", md, ABC_MD);
      checkOutput("hold_valid", {255'h0, valid}, 256'h1);
    end

    $display("[TB] reset mid-operation");
    applyStimulus(randBlock(), 1'b1);
    repeat (30) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_md", md, 256'h0);
    checkOutput("abort_valid", {255'h0, valid}, 256'h0);
    expQ.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (70) @(negedge clk);
    checkOutput("no_digest_after_abort", {255'h0, valid}, 256'h0);
    applyStimulus(EMPTY_BLK, 1'b1);
    waitDone(80);
    checkOutput("empty_after_abort", md, EMPTY_MD);

    $display("[TB] random blocks");
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      blk = randBlock();
      if (k == 3) blk = '1;
      if (k == 4) blk = '0;
      applyStimulus(blk, 1'b1);
      waitDone(80);
    end

    repeat (5) @(negedge clk);
    checkOutput("queue_drained", 256'(expQ.size()), 256'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
